// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: 2-flop line synchronizer, start-bit qualification at
// mid-bit, LSB-first data sampling on the oversample tick, stop-bit framing check.
//
// state       | meaning
// ------------+----------------------------------------------------------
// WAIT_HIGH   | after reset or a bad stop bit; wait for the line to idle high
// IDLE        | line idle, watching for a falling edge (start bit)
// START       | counting to mid start bit to confirm it is not a glitch
// DATA        | sampling DATA_BITS data bits, one per OVERSAMPLE ticks
// STOP        | sampling the stop bit; publish byte or flag framing error
module uart_receiver #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 Rx_CLK,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] Rx_Data,
   output logic                 Rx_Valid,
   output logic                 Frame_Err,
   output logic                 Rx_Busy
);

   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_WAIT_HIGH,
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e                 state_q;
   logic                   rx_meta_q;
   logic                   rx_q;
   logic [SW-1:0]          sample_cnt_q;
   logic [BW-1:0]          bit_cnt_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q;
   logic                   ferr_q;

   // Synchronizer resets high so reset release never looks like a start bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_meta_q <= 1'b1;
         rx_q      <= 1'b1;
      end else begin
         rx_meta_q <= RxD;
         rx_q      <= rx_meta_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_WAIT_HIGH;
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (Rx_CLK) begin
            unique case (state_q)
               S_WAIT_HIGH: begin
                  if (rx_q) state_q <= S_IDLE;
               end
               S_IDLE: begin
                  if (!rx_q) begin
                     sample_cnt_q <= '0;
                     state_q      <= S_START;
                  end
               end
               S_START: begin
                  if (sample_cnt_q == HALF_M1) begin
                     if (!rx_q) begin
                        sample_cnt_q <= '0;
                        bit_cnt_q    <= '0;
                        state_q      <= S_DATA;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     sample_cnt_q <= sample_cnt_q + SW'(1);
                  end
               end
               S_DATA: begin
                  if (sample_cnt_q == FULL_M1) begin
                     shift_q      <= {rx_q, shift_q[DATA_BITS-1:1]};
                     sample_cnt_q <= '0;
                     bit_cnt_q    <= bit_cnt_q + BW'(1);
                     if (bit_cnt_q == LAST_BIT) state_q <= S_STOP;
                  end else begin
                     sample_cnt_q <= sample_cnt_q + SW'(1);
                  end
               end
               S_STOP: begin
                  if (sample_cnt_q == FULL_M1) begin
                     sample_cnt_q <= '0;
                     if (rx_q) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                        ferr_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end else begin
                        // Line may be in a break; insist on idle-high before rearming.
                        ferr_q  <= 1'b1;
                        state_q <= S_WAIT_HIGH;
                     end
                  end else begin
                     sample_cnt_q <= sample_cnt_q + SW'(1);
                  end
               end
               default: state_q <= S_WAIT_HIGH;
            endcase
         end
      end
   end

   assign Rx_Data   = data_q;
   assign Rx_Valid  = valid_q;
   assign Frame_Err = ferr_q;
   assign Rx_Busy   = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: drives serial frames on a randomized tick divider and
// compares received bytes / error flag against a frame-level expectation model.
`timescale 1ns/1ps
module tb_uart_receiver;

   localparam int DB = 8;
   localparam int OS = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          Rx_CLK = 1'b0;
   logic          RxD = 1'b1;
   logic [DB-1:0] Rx_Data;
   logic          Rx_Valid;
   logic          Frame_Err;
   logic          Rx_Busy;

   uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .Rx_CLK    (Rx_CLK),
      .RxD       (RxD),
      .Rx_Data   (Rx_Data),
      .Rx_Valid  (Rx_Valid),
      .Frame_Err (Frame_Err),
      .Rx_Busy   (Rx_Busy)
   );

   always #5 CLK = ~CLK;

   int          checks = 0;
   int          failures = 0;
   int          div = 4;
   logic        tick_en = 1'b1;

   // frame-level model state
   logic [7:0]  exp_data = 8'h00;
   logic        exp_ferr = 1'b0;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];
   int          valid_run = 0;
   int          max_run = 0;

   // oversample tick: one CLK-wide pulse every div cycles
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge CLK);
         #1;
         if (!tick_en) begin
            cnt = 0;
            Rx_CLK = 1'b0;
         end else begin
            Rx_CLK = (cnt == div - 1);
            cnt = (cnt == div - 1) ? 0 : cnt + 1;
         end
      end
   end

   // record every cycle Rx_Valid is high and the longest pulse seen
   initial begin
      forever begin
         @(negedge CLK);
         if (Rx_Valid === 1'b1) begin
            got_q.push_back(Rx_Data);
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
         end else begin
            valid_run = 0;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog sim_time exceeded");
      $fatal(1, "watchdog");
   end

   // returns 2 ns after the CLK edge that consumed a tick
   task automatic wait_tick();
      int   n;
      logic seen;
      n = 0;
      seen = 1'b0;
      while (!seen) begin
         @(posedge CLK);
         seen = Rx_CLK;
         n++;
         if (!seen && n > 64) begin
            failures++;
            $display("FAIL tick_timeout waited=%0d cycles required a tick", n);
            seen = 1'b1;
         end
      end
      #2;
   endtask

   task automatic drive_bit(input logic v, input int n);
      RxD = v;
      repeat (n) wait_tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      drive_bit(1'b0, OS);
      for (int i = 0; i < DB; i++) drive_bit(b[i], OS);
      drive_bit(stop_ok, OS);
      if (stop_ok) begin
         exp_q.push_back(b);
         exp_data = b;
         exp_ferr = 1'b0;
      end else begin
         exp_ferr = 1'b1;
      end
   endtask

   task automatic clear_queues();
      got_q.delete();
      exp_q.delete();
      max_run = 0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (4) @(posedge CLK);
      #1;
      checks++;
      if ({Rx_Data, Rx_Valid, Frame_Err, Rx_Busy} !== 11'h0) begin
         failures++;
         $display("FAIL reset_outputs got data=%h v=%b fe=%b busy=%b required all 0",
                  Rx_Data, Rx_Valid, Frame_Err, Rx_Busy);
      end
      RST = 1'b0;
      exp_data = 8'h00;
      exp_ferr = 1'b0;
      drive_bit(1'b1, 4);
   endtask

   task automatic test_good_byte();
      logic [7:0] b;
      clear_queues();
      b = 8'hA5;
      drive_bit(1'b0, OS);
      for (int i = 0; i < DB; i++) drive_bit(b[i], OS);
      drive_bit(1'b1, 4);
      checks++;
      if (Rx_Busy !== 1'b1) begin
         failures++;
         $display("FAIL a5_busy_before_stop got=%b required=1", Rx_Busy);
      end
      drive_bit(1'b1, OS - 4);
      exp_q.push_back(b);
      exp_data = b;
      exp_ferr = 1'b0;
      drive_bit(1'b1, 4);
      checks++;
      if (Rx_Busy !== 1'b0) begin
         failures++;
         $display("FAIL a5_busy_after_stop got=%b required=0", Rx_Busy);
      end
      checks++;
      if (got_q.size() != 1 || max_run != 1) begin
         failures++;
         $display("FAIL a5_valid_pulses got cycles=%0d maxwidth=%0d required 1/1", got_q.size(), max_run);
      end
      checks++;
      if (Rx_Data !== exp_data || Frame_Err !== exp_ferr) begin
         failures++;
         $display("FAIL a5_data got=%h fe=%b required=%h fe=%b", Rx_Data, Frame_Err, exp_data, exp_ferr);
      end
   endtask

   task automatic test_false_start();
      clear_queues();
      drive_bit(1'b0, 3);
      checks++;
      if (Rx_Busy !== 1'b1) begin
         failures++;
         $display("FAIL glitch_busy_detect got=%b required=1", Rx_Busy);
      end
      drive_bit(1'b1, OS);
      checks++;
      if (Rx_Busy !== 1'b0) begin
         failures++;
         $display("FAIL glitch_back_idle got busy=%b required=0", Rx_Busy);
      end
      checks++;
      if (got_q.size() != 0 || Rx_Data !== exp_data) begin
         failures++;
         $display("FAIL glitch_no_data got pulses=%0d data=%h required 0/%h", got_q.size(), Rx_Data, exp_data);
      end
   endtask

   task automatic test_frame_error();
      clear_queues();
      send_frame(8'h3C, 1'b0);
      checks++;
      if (Frame_Err !== 1'b1 || got_q.size() != 0) begin
         failures++;
         $display("FAIL ferr_flag got fe=%b pulses=%0d required fe=1 pulses=0", Frame_Err, got_q.size());
      end
      checks++;
      if (Rx_Data !== exp_data) begin
         failures++;
         $display("FAIL ferr_data_kept got=%h required=%h", Rx_Data, exp_data);
      end
      drive_bit(1'b1, 20);
      send_frame(8'h01, 1'b1);
      drive_bit(1'b1, 4);
      checks++;
      if (got_q.size() != 1 || Rx_Data !== exp_data || Frame_Err !== exp_ferr) begin
         failures++;
         $display("FAIL ferr_recover got pulses=%0d data=%h fe=%b required 1/%h/%b",
                  got_q.size(), Rx_Data, Frame_Err, exp_data, exp_ferr);
      end
   endtask

   task automatic test_back_to_back();
      clear_queues();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      drive_bit(1'b1, 4);
      checks++;
      if (got_q.size() != exp_q.size() || max_run != 1) begin
         failures++;
         $display("FAIL b2b_count got=%0d width=%0d required=%0d width=1", got_q.size(), max_run, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL b2b_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b = 8'h55;
      clear_queues();
      drive_bit(1'b0, OS);
      for (int i = 0; i < 3; i++) drive_bit(b[i], OS);
      drive_bit(b[3], 8);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
      exp_data = 8'h00;
      exp_ferr = 1'b0;
      checks++;
      if ({Rx_Data, Rx_Valid, Frame_Err, Rx_Busy} !== 11'h0) begin
         failures++;
         $display("FAIL rstmid_outputs got data=%h v=%b fe=%b busy=%b required all 0",
                  Rx_Data, Rx_Valid, Frame_Err, Rx_Busy);
      end
      drive_bit(1'b0, 40);
      checks++;
      if (Rx_Busy !== 1'b0 || got_q.size() != 0) begin
         failures++;
         $display("FAIL rstmid_low_line got busy=%b pulses=%0d required 0/0", Rx_Busy, got_q.size());
      end
      drive_bit(1'b1, 4);
      send_frame(b, 1'b1);
      drive_bit(1'b1, 4);
      checks++;
      if (got_q.size() != 1 || Rx_Data !== exp_data || Frame_Err !== exp_ferr) begin
         failures++;
         $display("FAIL rstmid_recover got pulses=%0d data=%h fe=%b required 1/%h/%b",
                  got_q.size(), Rx_Data, Frame_Err, exp_data, exp_ferr);
      end
   endtask

   task automatic test_freeze();
      logic [7:0] b;
      b = 8'($urandom);
      clear_queues();
      drive_bit(1'b0, OS);
      for (int i = 0; i < 3; i++) drive_bit(b[i], OS);
      drive_bit(b[3], 8);
      tick_en = 1'b0;
      repeat (1000) begin
         @(posedge CLK);
         #1;
         RxD = 1'($urandom);
      end
      checks++;
      if (Rx_Busy !== 1'b1 || got_q.size() != 0 || Rx_Data !== exp_data) begin
         failures++;
         $display("FAIL freeze_hold got busy=%b pulses=%0d data=%h required 1/0/%h",
                  Rx_Busy, got_q.size(), Rx_Data, exp_data);
      end
      RxD = b[3];
      repeat (4) @(posedge CLK);
      #2;
      tick_en = 1'b1;
      drive_bit(b[3], 8);
      for (int i = 4; i < DB; i++) drive_bit(b[i], OS);
      drive_bit(1'b1, OS);
      exp_q.push_back(b);
      exp_data = b;
      exp_ferr = 1'b0;
      drive_bit(1'b1, 4);
      checks++;
      if (got_q.size() != 1 || Rx_Data !== exp_data) begin
         failures++;
         $display("FAIL freeze_resume got pulses=%0d data=%h required 1/%h", got_q.size(), Rx_Data, exp_data);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       ok;
      clear_queues();
      for (int f = 0; f < 8; f++) begin
         b  = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send_frame(b, ok);
         if (!ok) drive_bit(1'b1, $urandom_range(2, 6));
         else     drive_bit(1'b1, $urandom_range(0, 3));
         checks++;
         if (Rx_Data !== exp_data || Frame_Err !== exp_ferr) begin
            failures++;
            $display("FAIL rand_frame%0d got data=%h fe=%b required data=%h fe=%b",
                     f, Rx_Data, Frame_Err, exp_data, exp_ferr);
         end
      end
      drive_bit(1'b1, 4);
      checks++;
      if (got_q.size() != exp_q.size() || max_run > 1) begin
         failures++;
         $display("FAIL rand_count got=%0d width=%0d required=%0d width=1", got_q.size(), max_run, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            failures++;
            $display("FAIL rand_byte%0d got=%h required=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      div = $urandom_range(3, 6);
      test_reset();
      test_good_byte();
      test_false_start();
      test_frame_error();
      test_back_to_back();
      test_reset_mid_frame();
      test_freeze();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART serial receiver that sits directly downstream of the baud rate generator. It consumes the 16x-oversample tick `Rx_CLK` and the asynchronous serial line `RxD`. It recovers 8N1 frames (LSB first) by sampling mid-bit, and presents each good byte with a one-cycle valid strobe. Frames whose stop bit is bad are flagged and their data is discarded.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `OVERSAMPLE`, default 16: `Rx_CLK` ticks per bit; even, ≥4; must match the generator's ratio.
- `CLK` input, 1 bit: system clock; all logic on rising edge.
- `RST` input, 1 bit: reset; synchronous, active-high.
- `Rx_CLK` input, 1 bit: oversample tick; one-`CLK`-cycle enable pulse, not a clock.
- `RxD` input, 1 bit: asynchronous serial line; idles high.
- `Rx_Data` output, `DATA_BITS` wide: last correctly received byte.
- `Rx_Valid` output, 1 bit: one-`CLK`-cycle pulse when `Rx_Data` updates.
- `Frame_Err` output, 1 bit: level; last frame had a low stop bit.
- `Rx_Busy` output, 1 bit: high while a frame is in progress (states START, DATA, STOP).

## Operation
- **Synchronizer**
  - `RxD` passes through a 2-flop synchronizer clocked every `CLK`; both flops reset to 1.
  - All FSM decisions use the synchronized value, called `rx` below.
- **Counters**
  - `sample_cnt` is `$clog2(OVERSAMPLE)` bits wide.
  - `bit_cnt` is `$clog2(DATA_BITS+1)` bits wide.
  - `shift` is `DATA_BITS` wide.
- **Gating:** the FSM and counters change only on cycles where `Rx_CLK`=1. On all other cycles everything holds, except the `Rx_Valid` clear.
- **States:**
  - **WAIT_HIGH** (reset state)
    - On a tick with `rx`=1 → IDLE.
    - Guarantees no false start when leaving reset or recovering from a break.
  - **IDLE**
    - On a tick with `rx`=0: `sample_cnt`←0, go to START.
  - **START**
    - On a tick with `sample_cnt`==`OVERSAMPLE`/2−1:
      - If `rx`=0: `sample_cnt`←0, `bit_cnt`←0, go to DATA.
      - If `rx`=1: false start, go to IDLE.
    - On other ticks: `sample_cnt`++.
  - **DATA**
    - On a tick with `sample_cnt`==`OVERSAMPLE`−1:
      - `shift`←{`rx`, `shift`[`DATA_BITS`−1:1]} (LSB first).
      - `sample_cnt`←0, `bit_cnt`++.
      - When `bit_cnt` reaches `DATA_BITS`, go to STOP.
    - On other ticks: `sample_cnt`++.
  - **STOP**
    - On a tick with `sample_cnt`==`OVERSAMPLE`−1:
      - If `rx`=1: `Rx_Data`←`shift`, `Rx_Valid`←1, `Frame_Err`←0, go to IDLE.
      - If `rx`=0: `Frame_Err`←1, `Rx_Data` unchanged, no `Rx_Valid`, go to WAIT_HIGH.
    - On other ticks: `sample_cnt`++.
- **Outputs:**
  - `Rx_Valid` is cleared on the next `CLK` cycle regardless of `Rx_CLK`.
  - `Frame_Err` holds until the next good stop bit or reset.
  - `Rx_Busy` is a combinational decode of the state.

## Timing
- **Reset values:** `Rx_Data`=0, `Rx_Valid`=0, `Frame_Err`=0, `Rx_Busy`=0, state WAIT_HIGH, counters 0, synchronizer flops 1.
- **Start detection:**
  - 2 `CLK` synchronizer latency, plus 0..1 tick of detection delay.
  - The start check falls `OVERSAMPLE`/2 ticks after the detection tick.
  - Each data bit is sampled `OVERSAMPLE` ticks after the previous sample.
- **Output latency:**
  - `Rx_Valid` rises on the `CLK` edge that registers the stop-sample tick.
  - `Rx_Valid` is high for exactly 1 `CLK` cycle.
  - `Rx_Data` is stable from that edge until the next good frame.
- **Back-to-back frames:** the next start bit can be detected on the tick immediately after the stop sample, so no idle gap is required.
- **Reset mid-frame:**
  - Abort takes effect on the next edge; no `Rx_Valid` is issued.
  - No new frame is accepted until `rx` is seen high on a tick.
- **Simultaneous `RST` and `Rx_CLK`:** `RST` wins.
- **`Rx_CLK` held low:** all state frozen regardless of `RxD`.

## Test plan
- Drive 0xA5, 16 ticks/bit, stop high → exactly one `Rx_Valid` pulse of 1 `CLK`, `Rx_Data`=0xA5, `Frame_Err`=0, `Rx_Busy` 1→0 at the stop sample.
- `RxD` low for 3 ticks, then high → no `Rx_Valid`, return to IDLE at the mid-start check, `Rx_Data` unchanged.
- Drive 0x3C with stop bit low → `Frame_Err`=1, no `Rx_Valid`, `Rx_Data` still 0xA5.
  - Follow with `RxD` high, then 0x01 → `Rx_Valid`, `Rx_Data`=0x01, `Frame_Err`=0.
- 0x00 then 0xFF back-to-back with a single stop bit → two `Rx_Valid` pulses, values 0x00 then 0xFF.
- Assert `RST` mid-byte of 0x55 while `RxD` is low → all outputs 0 next cycle.
  - Keep `RxD` low 40 ticks → no start detected.
  - Then line high, then 0x55 → received correctly.
- `Rx_CLK` tied low while `RxD` toggles for 1000 `CLK` → `Rx_Busy`, `Rx_Valid` and `Rx_Data` unchanged.
